// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, scoreboard and register-file write bus for regfile_wb_arbiter.
// REGFILE_WB_BYPASS_EN adds the byp_hit_1/byp_hit_2/byp_data signals.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 24
);
    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_index;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [4:0]        mem_index;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [4:0]        issue_index;
    logic [4:0]        rd_index_1;
    logic [4:0]        rd_index_2;
    logic              rd_busy_1;
    logic              rd_busy_2;
    logic              sb_err;
    logic [4:0]        rf_write_index;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_enable;
`ifdef REGFILE_WB_BYPASS_EN
    logic              byp_hit_1;
    logic              byp_hit_2;
    logic [DATA_W-1:0] byp_data;
`endif

    modport master (
        output alu_valid, alu_index, alu_data,
        output mem_valid, mem_index, mem_data,
        output issue_valid, issue_index, rd_index_1, rd_index_2,
        input  alu_ready, mem_ready, rd_busy_1, rd_busy_2, sb_err,
        input  rf_write_index, rf_write_data, rf_write_enable
`ifdef REGFILE_WB_BYPASS_EN
        , input byp_hit_1, byp_hit_2, byp_data
`endif
    );

    modport slave (
        input  alu_valid, alu_index, alu_data,
        input  mem_valid, mem_index, mem_data,
        input  issue_valid, issue_index, rd_index_1, rd_index_2,
        output alu_ready, mem_ready, rd_busy_1, rd_busy_2, sb_err,
        output rf_write_index, rf_write_data, rf_write_enable
`ifdef REGFILE_WB_BYPASS_EN
        , output byp_hit_1, byp_hit_2, byp_data
`endif
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of ALU/load writebacks onto one register-file write port, with a
// pending-write scoreboard. Optional write-stage bypass under REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned SHORT_W   = 16,
    parameter int unsigned LONG_BASE = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    typedef enum logic {GrAlu, GrMem} grant_e;

    grant_e            r_last_grant;
    logic [31:0]       r_busy;
    logic              r_sb_err;
    logic              r_wr_en;
    logic [4:0]        r_wr_index;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_grant_alu;
    logic              w_grant_mem;
    logic              w_accept;
    logic [4:0]        w_idx;
    logic [DATA_W-1:0] w_data_raw;
    logic [DATA_W-1:0] w_data;
    logic [31:0]       w_busy_d;
    logic              w_err_set;

    // ALU wins unless the MEM side is also requesting and the ALU won last time.
    always_comb begin
        w_grant_alu = bus.alu_valid && (!bus.mem_valid || (r_last_grant == GrMem));
        w_grant_mem = bus.mem_valid && !w_grant_alu;
        w_accept    = w_grant_alu || w_grant_mem;
        w_idx       = w_grant_alu ? bus.alu_index : bus.mem_index;
        w_data_raw  = w_grant_alu ? bus.alu_data : bus.mem_data;
        if ({27'd0, w_idx} < LONG_BASE) begin
            w_data = {{(DATA_W - SHORT_W){1'b0}}, w_data_raw[SHORT_W-1:0]};
        end else begin
            w_data = w_data_raw;
        end
    end

    // Clear before set so a same-edge issue to the written index keeps it busy.
    always_comb begin
        w_busy_d  = r_busy;
        w_err_set = bus.issue_valid && r_busy[bus.issue_index];
        if (w_accept) begin
            w_busy_d[w_idx] = 1'b0;
        end
        if (bus.issue_valid) begin
            w_busy_d[bus.issue_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GrMem;
            r_busy       <= '0;
            r_sb_err     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_index   <= '0;
            r_wr_data    <= '0;
        end else begin
            r_busy   <= w_busy_d;
            r_sb_err <= r_sb_err || w_err_set;
            r_wr_en  <= w_accept;
            if (w_accept) begin
                r_wr_index   <= w_idx;
                r_wr_data    <= w_data;
                r_last_grant <= w_grant_alu ? GrAlu : GrMem;
            end
        end
    end

    assign bus.alu_ready       = w_grant_alu;
    assign bus.mem_ready       = w_grant_mem;
    assign bus.sb_err          = r_sb_err;
    assign bus.rf_write_enable = r_wr_en;
    assign bus.rf_write_index  = r_wr_index;
    assign bus.rf_write_data   = r_wr_data;

`ifdef REGFILE_WB_BYPASS_EN
    logic w_hit_1;
    logic w_hit_2;

    assign w_hit_1       = r_wr_en && (r_wr_index == bus.rd_index_1);
    assign w_hit_2       = r_wr_en && (r_wr_index == bus.rd_index_2);
    assign bus.byp_hit_1 = w_hit_1;
    assign bus.byp_hit_2 = w_hit_2;
    assign bus.byp_data  = r_wr_data;
    assign bus.rd_busy_1 = r_busy[bus.rd_index_1] && !w_hit_1;
    assign bus.rd_busy_2 = r_busy[bus.rd_index_2] && !w_hit_2;
`else
    assign bus.rd_busy_1 = r_busy[bus.rd_index_1];
    assign bus.rd_busy_2 = r_busy[bus.rd_index_2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural model.
// Bypass checks are included when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.DATA_W(24)) ifc ();

    regfile_wb_arbiter #(
        .DATA_W   (24),
        .SHORT_W  (16),
        .LONG_BASE(28)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 1 = ALU, 2 = MEM.
    int          m_last;
    bit          m_busy [32];
    bit          m_err;
    bit          m_we;
    int          m_widx;
    logic [23:0] m_wdata;
    int          last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ifc.alu_valid   = 1'b0;
        ifc.alu_index   = '0;
        ifc.alu_data    = '0;
        ifc.mem_valid   = 1'b0;
        ifc.mem_index   = '0;
        ifc.mem_data    = '0;
        ifc.issue_valid = 1'b0;
        ifc.issue_index = '0;
        ifc.rd_index_1  = '0;
        ifc.rd_index_2  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_last  = 2;
        m_err   = 0;
        m_we    = 0;
        m_widx  = 0;
        m_wdata = '0;
        last_g  = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        chk("rst_we", ifc.rf_write_enable, 0);
        chk("rst_idx", ifc.rf_write_index, 0);
        chk("rst_data", ifc.rf_write_data, 0);
        chk("rst_err", ifc.sb_err, 0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: combinational checks before the edge, registered checks after it.
    task automatic tick();
        int g;
        bit hit1, hit2, err_new;
        int wi;
        @(negedge clk);
        g = 0;
        if (ifc.alu_valid && ifc.mem_valid) g = (m_last == 2) ? 1 : 2;
        else if (ifc.alu_valid) g = 1;
        else if (ifc.mem_valid) g = 2;
        chk("alu_ready", ifc.alu_ready, g == 1);
        chk("mem_ready", ifc.mem_ready, g == 2);
        chk("one_ready", ifc.alu_ready & ifc.mem_ready, 0);
        hit1 = 0;
        hit2 = 0;
`ifdef REGFILE_WB_BYPASS_EN
        hit1 = m_we && (m_widx == int'(ifc.rd_index_1));
        hit2 = m_we && (m_widx == int'(ifc.rd_index_2));
        chk("byp_hit_1", ifc.byp_hit_1, hit1);
        chk("byp_hit_2", ifc.byp_hit_2, hit2);
        chk("byp_data", ifc.byp_data, m_wdata);
`endif
        chk("rd_busy_1", ifc.rd_busy_1, m_busy[ifc.rd_index_1] && !hit1);
        chk("rd_busy_2", ifc.rd_busy_2, m_busy[ifc.rd_index_2] && !hit2);
        err_new = ifc.issue_valid && m_busy[ifc.issue_index];
        if (err_new) m_err = 1;
        if (g != 0) begin
            wi      = (g == 1) ? int'(ifc.alu_index) : int'(ifc.mem_index);
            m_wdata = (g == 1) ? ifc.alu_data : ifc.mem_data;
            if (wi < 28) m_wdata = m_wdata % 24'h010000;
            m_widx  = wi;
            m_we    = 1;
            m_last  = g;
            m_busy[wi] = 0;
        end else begin
            m_we = 0;
        end
        if (ifc.issue_valid) m_busy[ifc.issue_index] = 1;
        last_g = g;
        @(posedge clk);
        #1;
        chk("rf_we", ifc.rf_write_enable, m_we);
        chk("rf_idx", ifc.rf_write_index, m_widx);
        chk("rf_data", ifc.rf_write_data, m_wdata);
        chk("sb_err", ifc.sb_err, m_err);
    endtask

    function automatic logic [4:0] rnd_idx();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(24, 31));
    endfunction

    int  exp_seq [4] = '{29, 3, 29, 3};
    bit  alu_pend;
    bit  mem_pend;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        do_reset();

        // Single ALU write to a short register: upper byte masked.
        ifc.alu_valid = 1'b1;
        ifc.alu_index = 5'd5;
        ifc.alu_data  = 24'hABCDEF;
        tick();
        chk("t1_we", ifc.rf_write_enable, 1);
        chk("t1_idx", ifc.rf_write_index, 5);
        chk("t1_data", ifc.rf_write_data, 24'h00CDEF);
        ifc.alu_valid = 1'b0;
        tick();
        chk("t1_we_low", ifc.rf_write_enable, 0);

        // Continuous contention alternates, ALU first after reset.
        do_reset();
        ifc.alu_valid = 1'b1;
        ifc.alu_index = 5'd29;
        ifc.alu_data  = 24'h123456;
        ifc.mem_valid = 1'b1;
        ifc.mem_index = 5'd3;
        ifc.mem_data  = 24'h00BEEF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_seq", ifc.rf_write_index, exp_seq[k]);
        end
        chk("rr_long_data", ifc.rf_write_data, 24'h00BEEF);
        clear_inputs();
        tick();

        // Scoreboard set/clear, including set-wins on a simultaneous issue.
        ifc.issue_valid = 1'b1;
        ifc.issue_index = 5'd7;
        tick();
        ifc.issue_valid = 1'b0;
        ifc.rd_index_1  = 5'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("busy7_held", ifc.rd_busy_1, 1);
        end
        ifc.alu_valid = 1'b1;
        ifc.alu_index = 5'd7;
        ifc.alu_data  = 24'h000777;
        tick();
        chk("busy7_clr", ifc.rd_busy_1, 0);
        ifc.issue_valid = 1'b1;
        ifc.issue_index = 5'd7;
        tick();
        ifc.alu_valid   = 1'b0;
        ifc.issue_valid = 1'b0;
        tick();
        chk("busy7_set_wins", ifc.rd_busy_1, 1);
        chk("no_err_yet", ifc.sb_err, 0);

        // Double issue sets the sticky error.
        do_reset();
        ifc.issue_valid = 1'b1;
        ifc.issue_index = 5'd12;
        tick();
        tick();
        ifc.issue_valid = 1'b0;
        tick();
        chk("sb_err_set", ifc.sb_err, 1);
        tick();
        chk("sb_err_sticky", ifc.sb_err, 1);

        // Reset with a write in flight drops it and restores ALU priority.
        do_reset();
        ifc.issue_valid = 1'b1;
        ifc.issue_index = 5'd31;
        ifc.mem_valid   = 1'b1;
        ifc.mem_index   = 5'd31;
        ifc.mem_data    = 24'hFEDCBA;
        tick();
        ifc.issue_valid = 1'b0;
        tick();
        chk("inflight_we", ifc.rf_write_enable, 1);
        do_reset();
        ifc.rd_index_1 = 5'd31;
        #1;
        chk("rst_busy31", ifc.rd_busy_1, 0);
        ifc.alu_valid = 1'b1;
        ifc.alu_index = 5'd1;
        ifc.mem_valid = 1'b1;
        ifc.mem_index = 5'd2;
        tick();
        chk("rst_alu_first", ifc.rf_write_index, 1);
        clear_inputs();
        tick();

`ifdef REGFILE_WB_BYPASS_EN
        // Bypass hides the pending bit during the write cycle.
        do_reset();
        ifc.issue_valid = 1'b1;
        ifc.issue_index = 5'd9;
        tick();
        ifc.issue_valid = 1'b0;
        ifc.alu_valid   = 1'b1;
        ifc.alu_index   = 5'd9;
        ifc.alu_data    = 24'h00F00D;
        ifc.rd_index_2  = 5'd9;
        tick();
        ifc.alu_valid = 1'b0;
        #1;
        chk("byp_hit2", ifc.byp_hit_2, 1);
        chk("byp_data9", ifc.byp_data, 24'h00F00D);
        chk("byp_busy2", ifc.rd_busy_2, 0);
        tick();
`endif

        // Randomized traffic; sources hold their request until accepted.
        do_reset();
        alu_pend = 0;
        mem_pend = 0;
        for (int i = 0; i < 600; i++) begin
            if (!alu_pend) begin
                ifc.alu_valid = 1'($urandom_range(0, 1));
                ifc.alu_index = rnd_idx();
                ifc.alu_data  = 24'($urandom);
            end
            if (!mem_pend) begin
                ifc.mem_valid = 1'($urandom_range(0, 1));
                ifc.mem_index = rnd_idx();
                ifc.mem_data  = 24'($urandom);
            end
            ifc.issue_valid = ($urandom_range(0, 3) == 0);
            ifc.issue_index = rnd_idx();
            ifc.rd_index_1  = rnd_idx();
            ifc.rd_index_2  = rnd_idx();
            tick();
            alu_pend = ifc.alu_valid && (last_g != 1);
            mem_pend = ifc.mem_valid && (last_g != 2);
            if (i % 150 == 149) begin
                do_reset();
                alu_pend = 0;
                mem_pend = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
